// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per
// clock, MSB first. A zero divisor short-circuits straight to the result.
//
// Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
// DONE). The accepting edge captures dividend and divisor, so both may change
// freely afterwards. done is a one-cycle pulse; quotient, remainder and
// div_by_zero are valid from that cycle. They are held until the next
// completion overwrites them.
module seq_divider #(
    parameter int LENGTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LENGTH-1:0] dividend,
    input  logic [LENGTH-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [LENGTH-1:0] quotient,
    output logic [LENGTH-1:0] remainder,
    output logic [1:0]        state_dbg
);

    // Counter must be able to hold LENGTH itself.
    localparam int CW = $clog2(LENGTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    // Partial remainder. After each step it is always below the divisor, so
    // it fits in LENGTH bits. The extra bit lives in the LENGTH+1-bit trial
    // value below, so the restore path never truncates.
    logic [LENGTH-1:0] part_rem, part_rem_n;
    logic [LENGTH-1:0] q_shift, q_shift_n;
    logic [LENGTH-1:0] dsr, dsr_n;
    logic [LENGTH-1:0] quot_n, rem_n;
    logic              dbz_n;

    logic [LENGTH:0]   trial;
    logic [LENGTH:0]   diff;
    logic              no_borrow;

    // Trial subtraction: shift the next dividend bit into the remainder, subtract the divisor.
    always_comb begin
        trial     = {part_rem, q_shift[LENGTH-1]};
        diff      = trial - {1'b0, dsr};
        no_borrow = ~diff[LENGTH];
    end

    // Next-state and datapath update; every target holds unless a branch changes it.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        part_rem_n = part_rem;
        q_shift_n  = q_shift;
        dsr_n      = dsr;
        quot_n     = quotient;
        rem_n      = remainder;
        dbz_n      = div_by_zero;

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    dsr_n = divisor;
                    if (divisor != '0) begin
                        state_n    = CALC;
                        cnt_n      = CW'(LENGTH);
                        part_rem_n = '0;
                        q_shift_n  = dividend;
                    end else begin
                        // Divide by zero: quotient saturates, remainder is the dividend.
                        state_n = DONE;
                        quot_n  = '1;
                        rem_n   = dividend;
                        dbz_n   = 1'b1;
                    end
                end
            end

            CALC: begin
                part_rem_n = no_borrow ? diff[LENGTH-1:0] : trial[LENGTH-1:0];
                q_shift_n  = {q_shift[LENGTH-2:0], no_borrow};
                cnt_n      = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    // Last bit: publish the freshly updated values.
                    state_n = DONE;
                    quot_n  = {q_shift[LENGTH-2:0], no_borrow};
                    rem_n   = no_borrow ? diff[LENGTH-1:0] : trial[LENGTH-1:0];
                    dbz_n   = 1'b0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            part_rem    <= '0;
            q_shift     <= '0;
            dsr         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            part_rem    <= part_rem_n;
            q_shift     <= q_shift_n;
            dsr         <= dsr_n;
            quotient    <= quot_n;
            remainder   <= rem_n;
            div_by_zero <= dbz_n;
        end
    end

    // Status decoded straight from the state register so reset clears it at once.
    always_comb begin
        busy      = (state == CALC);
        done      = (state == DONE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random divisions on an 8-bit and a 32-bit
// instance, checked against plain integer / and % arithmetic.
module tb_seq_divider;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s8, busy8, done8, dz8;
  logic [7:0]  a8, b8, q8, r8;
  logic [1:0]  st8;
  logic        s32, busy32, done32, dz32;
  logic [31:0] a32, b32, q32, r32;
  logic [1:0]  st32;

  seq_divider #(.LENGTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .div_by_zero(dz8),
    .quotient(q8), .remainder(r8), .state_dbg(st8)
  );

  seq_divider #(.LENGTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(s32), .dividend(a32), .divisor(b32),
    .busy(busy32), .done(done32), .div_by_zero(dz32),
    .quotient(q32), .remainder(r32), .state_dbg(st32)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, saturated quotient on divide by zero.
  function automatic void ref_div(input int w, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic dz);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (b == 64'd0) begin
      q = mask; r = a; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  function automatic logic [63:0] obs_q(input bit wide);
    return wide ? 64'(q32) : 64'(q8);
  endfunction
  function automatic logic [63:0] obs_r(input bit wide);
    return wide ? 64'(r32) : 64'(r8);
  endfunction
  function automatic logic obs_busy(input bit wide);
    return wide ? busy32 : busy8;
  endfunction
  function automatic logic obs_done(input bit wide);
    return wide ? done32 : done8;
  endfunction
  function automatic logic obs_dz(input bit wide);
    return wide ? dz32 : dz8;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit wide, input logic st, input logic [63:0] a, input logic [63:0] b);
    if (wide) begin
      s32 = st; a32 = a[31:0]; b32 = b[31:0];
    end else begin
      s8 = st; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  // One complete division: latency, busy length, held outputs, result, single done.
  task automatic run_op(input bit wide, input logic [63:0] a, input logic [63:0] b, input bit noise);
    logic [63:0] eq, er, prev_q;
    logic        edz;
    int          w, lat, busy_cnt, overlap;
    w = wide ? 32 : 8;
    ref_div(w, a, b, eq, er, edz);
    exp_q.push_back(eq);
    exp_q.push_back(er);
    @(negedge clk);
    prev_q = obs_q(wide);
    drive(wide, 1'b1, a, b);
    @(negedge clk);
    drive(wide, 1'b0, 64'd0, 64'd0);
    lat = 1; busy_cnt = 0; overlap = 0;
    while (!obs_done(wide) && lat < 80) begin
      if (obs_busy(wide)) busy_cnt++;
      if (lat == 3) check("hold_quotient_in_calc", obs_q(wide), prev_q);
      if (noise) begin
        if (lat == 2) drive(wide, 1'b1, 64'd50, 64'd5);
        else drive(wide, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      end
      @(negedge clk);
      lat++;
    end
    drive(wide, 1'b0, 64'd0, 64'd0);
    if (obs_busy(wide) && obs_done(wide)) overlap = 1;
    check("latency", 64'(lat), (b == 64'd0) ? 64'd1 : 64'(w + 1));
    check("busy_cycles", 64'(busy_cnt), (b == 64'd0) ? 64'd0 : 64'(w));
    check("busy_done_overlap", 64'(overlap), 64'd0);
    check("quotient", obs_q(wide), exp_q.pop_front());
    check("remainder", obs_r(wide), exp_q.pop_front());
    check("div_by_zero", 64'(obs_dz(wide)), 64'(edz));
    @(negedge clk);
    check("single_done_pulse", 64'(obs_done(wide)), 64'd0);
    check("hold_quotient_idle", obs_q(wide), eq);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, saw_done;
    rst = 1'b1;
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 64'd0, 64'd0);
    #2;
    check("reset_busy", 64'(busy8), 64'd0);
    check("reset_done", 64'(done8), 64'd0);
    check("reset_quotient", 64'(q8), 64'd0);
    check("reset_remainder", 64'(r8), 64'd0);
    check("reset_dz", 64'(dz8), 64'd0);
    check("reset_quotient32", 64'(q32), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 64'd100, 64'd7, 1'b0);
    run_op(1'b1, 64'hFFFF_FFFF, 64'd1, 1'b0);
    run_op(1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 64'd5, 64'd9, 1'b0);
    run_op(1'b0, 64'd200, 64'd0, 1'b0);
    run_op(1'b0, 64'd100, 64'd7, 1'b1);

    // Asynchronous reset between edges during CALC.
    @(negedge clk);
    drive(1'b0, 1'b1, 64'd255, 64'd16);
    @(negedge clk);
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", 64'(busy8), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    check("abort_quotient", 64'(q8), 64'd0);
    check("abort_remainder", 64'(r8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) saw_done++;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    run_op(1'b0, 64'd255, 64'd16, 1'b0);

    // start held high across two operations.
    @(negedge clk);
    drive(1'b0, 1'b1, 64'd81, 64'd9);
    @(negedge clk);
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", 64'(lat), 64'd9);
    check("b2b_first_quotient", 64'(q8), 64'd9);
    check("b2b_first_remainder", 64'(r8), 64'd0);
    a8 = 8'd81; b8 = 8'd10;
    @(negedge clk);
    check("b2b_restart_busy", 64'(busy8), 64'd1);
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s8 = 1'b0;
    check("b2b_second_latency", 64'(lat), 64'd9);
    check("b2b_second_quotient", 64'(q8), 64'd8);
    check("b2b_second_remainder", 64'(r8), 64'd1);
    @(negedge clk);
    check("b2b_no_third_done", 64'(done8), 64'd0);

    // Random operands, occasional zero divisor.
    for (int i = 0; i < 24; i++) begin
      logic [63:0] ra, rb;
      ra = 64'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom_range(1, 255));
      run_op(1'b0, ra, rb, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 8; i++) begin
      logic [63:0] ra, rb;
      ra = 64'($urandom);
      rb = 64'($urandom >> $urandom_range(0, 31));
      run_op(1'b1, ra, rb, 1'b0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
